// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared widths, entry type and PC helpers for the fetch front end
// Contents:
//   WORD, INST_SIZE   address and instruction widths
//   FETCH_DEPTH       default prefetch FIFO depth
//   fetch_entry_t     one buffered fetch: {pc, inst}
//   align_pc()        clears the two low address bits of a redirect target
package inst_fetch_queue_pkg;

  localparam int WORD        = 64;
  localparam int INST_SIZE   = 32;
  localparam int FETCH_DEPTH = 4;

  typedef struct packed {
    logic [WORD-1:0]      pc;
    logic [INST_SIZE-1:0] inst;
  } fetch_entry_t;

  function automatic logic [WORD-1:0] align_pc(input logic [WORD-1:0] pc);
    return {pc[WORD-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// rtl/inst_fetch_queue_fetch_fifo.sv - parameterised synchronous FIFO with flush and simultaneous push/pop
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             clears pointers and count next edge; overrides push/pop
//   push, push_data   write one entry at the tail (caller guarantees not full unless popping)
//   pop               consume the head entry (caller guarantees not empty)
//   head_data         entry at the read pointer
//   count, full, empty occupancy status
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW:0]      count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (push) begin
        mem_d[wptr_q] = push_data;
        wptr_d        = wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says it was written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rptr_q];
  assign count     = count_q;
  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch front end with prefetch FIFO and redirect flush
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   IAB                        fetch address to inst_mem (registered fetch_pc)
//   IDB                        instruction returned by inst_mem for IAB, same cycle
//   redirect_valid/pc          flush queue and restart fetch at aligned redirect_pc
//   out_valid/inst/pc, out_ready  head entry handshake to decode
//   occupancy                  current number of buffered entries
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int              DEPTH    = FETCH_DEPTH,
  parameter logic [WORD-1:0] PC_STEP  = 64'd4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [WORD-1:0]        IAB,
  input  logic [INST_SIZE-1:0]   IDB,
  input  logic                   redirect_valid,
  input  logic [WORD-1:0]        redirect_pc,
  output logic                   out_valid,
  output logic [INST_SIZE-1:0]   out_inst,
  output logic [WORD-1:0]        out_pc,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] occupancy
);

  logic [WORD-1:0] fetch_pc_q, fetch_pc_d;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            push, pop;
  logic            fifo_full, fifo_empty;

  assign IAB       = fetch_pc_q;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid & out_ready;
  // A full queue can still take the fetch when the head leaves this cycle.
  assign push      = !redirect_valid & (!fifo_full | pop);

  assign push_entry.pc   = fetch_pc_q;
  assign push_entry.inst = IDB;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fetch_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Stale storage is hidden while empty so decode never sees leftover data.
  assign out_inst = fifo_empty ? '0 : head_entry.inst;
  assign out_pc   = fifo_empty ? '0 : head_entry.pc;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue against a queue-based model
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] IAB;
  logic [31:0] IDB;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_ready;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  // inst_mem: word n holds F800_0000 + n
  assign IDB = 32'hF800_0000 + IAB[33:2];

  inst_fetch_queue #(
    .RESET_PC (64'h0),
    .DEPTH    (DEPTH),
    .PC_STEP  (64'd4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IAB            (IAB),
    .IDB            (IDB),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .occupancy      (occupancy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: next fetch address plus a queue of buffered PCs.
  logic [63:0] m_pc;
  logic [63:0] mq[$];

  wire [163:0] observed = {out_valid, out_pc, out_inst, occupancy, IAB};

  function automatic logic [163:0] expected();
    logic        v;
    logic [63:0] pc;
    logic [31:0] inst;
    v    = (mq.size() > 0);
    pc   = v ? mq[0] : 64'h0;
    inst = v ? (32'hF800_0000 + pc[33:2]) : 32'h0;
    return {v, pc, inst, 3'(mq.size()), m_pc};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = 64'h0;
  endtask

  // Apply inputs for one clock, advance the model, wait until just after the edge.
  task automatic cycle(input logic rdy, input logic rv, input logic [63:0] rpc);
    logic do_pop, do_push;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    do_pop  = (mq.size() > 0) && rdy;
    do_push = !rv && ((mq.size() < DEPTH) || do_pop);
    if (rv) begin
      mq.delete();
      m_pc = {rpc[63:2], 2'b00};
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    rst_n          = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    model_reset();
    #1;
    vectors++;
    if (observed !== expected()) begin
      miscompares++;
      $display("FAIL reset_state got %h want %h", observed, expected());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 64'h0);
      vectors++;
      if (observed !== expected()) begin
        miscompares++;
        $display("FAIL reset_seq_model cyc %0d got %h want %h", i, observed, expected());
      end
      vectors++;
      if ({out_valid, out_pc, out_inst, occupancy} !== {1'b1, 64'(4 * i), 32'hF800_0000 + 32'(i), 3'd1}) begin
        miscompares++;
        $display("FAIL reset_seq cyc %0d got pc %h inst %h occ %0d want pc %h occ 1",
                 i, out_pc, out_inst, occupancy, 64'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 64'h0);
      vectors++;
      if (observed !== expected()) begin
        miscompares++;
        $display("FAIL backpressure_model cyc %0d got %h want %h", i, observed, expected());
      end
      vectors++;
      if (occupancy !== 3'((i < 3) ? i + 1 : 4)) begin
        miscompares++;
        $display("FAIL backpressure_occ cyc %0d got %0d want %0d", i, occupancy, (i < 3) ? i + 1 : 4);
      end
    end
    vectors++;
    if ({IAB, out_pc} !== {64'd16, 64'd0}) begin
      miscompares++;
      $display("FAIL backpressure_hold got IAB %h pc %h want IAB 10 pc 0", IAB, out_pc);
    end
  endtask

  task automatic test_full_push_pop();
    cycle(1'b1, 1'b0, 64'h0);
    vectors++;
    if ({occupancy, IAB, out_pc} !== {3'd4, 64'd20, 64'd4}) begin
      miscompares++;
      $display("FAIL full_push_pop got occ %0d IAB %h pc %h want occ 4 IAB 14 pc 4", occupancy, IAB, out_pc);
    end
    for (int i = 2; i < 5; i++) begin
      cycle(1'b1, 1'b0, 64'h0);
      vectors++;
      if (observed !== expected() || out_pc !== 64'(4 * i)) begin
        miscompares++;
        $display("FAIL drain_order step %0d got %h want %h", i, observed, expected());
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 64'h0);
    vectors++;
    if (occupancy !== 3'd3) begin
      miscompares++;
      $display("FAIL redirect_setup got occ %0d want 3", occupancy);
    end
    cycle(1'b0, 1'b1, 64'h0000_0000_0000_0203);
    vectors++;
    if ({occupancy, out_valid, IAB} !== {3'd0, 1'b0, 64'h200}) begin
      miscompares++;
      $display("FAIL redirect_flush got occ %0d valid %b IAB %h want occ 0 valid 0 IAB 200",
               occupancy, out_valid, IAB);
    end
    cycle(1'b0, 1'b0, 64'h0);
    vectors++;
    if ({out_valid, out_pc} !== {1'b1, 64'h200}) begin
      miscompares++;
      $display("FAIL redirect_first got valid %b pc %h want valid 1 pc 200", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] want [4];
    want[0] = 64'hFFFF_FFFF_FFFF_FFF8;
    want[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    want[2] = 64'h0;
    want[3] = 64'h4;
    cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    vectors++;
    if (IAB !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      miscompares++;
      $display("FAIL wrap_redirect got IAB %h want FFFFFFFFFFFFFFF8", IAB);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 64'h0);
      vectors++;
      if ({out_valid, out_pc} !== {1'b1, want[i]} || observed !== expected()) begin
        miscompares++;
        $display("FAIL wrap_seq step %0d got valid %b pc %h want pc %h", i, out_valid, out_pc, want[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 64'h0);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, occupancy, IAB, out_pc} !== {1'b0, 3'd0, 64'h0, 64'h0}) begin
      miscompares++;
      $display("FAIL async_reset got valid %b occ %0d IAB %h pc %h want all 0", out_valid, occupancy, IAB, out_pc);
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 64'h0);
      vectors++;
      if (observed !== expected() || out_pc !== 64'(4 * i)) begin
        miscompares++;
        $display("FAIL async_resume cyc %0d got %h want %h", i, observed, expected());
      end
    end
  endtask

  task automatic test_random();
    logic        rdy, rv;
    logic [63:0] rpc;
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rpc = {32'hFFFF_FFFF, 24'hFF_FFFF, 8'($urandom_range(0, 255))};
      cycle(rdy, rv, rpc);
      vectors++;
      if (observed !== expected()) begin
        miscompares++;
        $display("FAIL random cyc %0d got %h want %h", i, observed, expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_full_push_pop();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
